// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction ROM address, resolves `j`
// in-stage and loads the IF/ID pipeline register.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RUN   | fetching one instruction per cycle
// S_HALT  | self-jump seen; PC frozen until redirect or reset
// S_FAULT | fetch attempted at PC >= MEM_DEPTH; frozen until redirect
module instruction_fetch #(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter int         MEM_DEPTH = 6,
    parameter int         COUNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [7:0]         redirect_pc,
    output logic [7:0]         imem_addr,
    input  logic [7:0]         imem_data,
    output logic               if_valid,
    output logic [7:0]         if_instr,
    output logic [7:0]         if_pc,
    output logic               halted,
    output logic               fault,
    output logic [COUNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    // Nine bits so a depth of 256 still compares correctly.
    localparam logic [8:0] DEPTH = 9'(MEM_DEPTH);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] pc;
    logic [7:0] seq_pc;
    logic [7:0] jump_pc;
    logic [7:0] next_pc;
    logic [7:0] offset;
    logic       is_jump;
    logic       in_range;
    logic       self_jump;
    logic       fetch_en;

    always_comb begin
        is_jump   = (imem_data[7:6] == 2'b11);
        offset    = {{6{imem_data[1]}}, imem_data[1:0]};
        seq_pc    = pc + 8'd1;
        jump_pc   = seq_pc + offset;
        next_pc   = is_jump ? jump_pc : seq_pc;
        in_range  = ({1'b0, pc} < DEPTH);
        self_jump = is_jump && (jump_pc == pc);
        fetch_en  = (state == S_RUN) && !stall && !redirect_valid && in_range;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = S_RUN;
        end else if (!stall) begin
            case (state)
                S_RUN: begin
                    if (!in_range) begin
                        state_nxt = S_FAULT;
                    end else if (self_jump) begin
                        state_nxt = S_HALT;
                    end
                end
                S_HALT:  state_nxt = S_HALT;
                S_FAULT: state_nxt = S_FAULT;
                default: state_nxt = S_RUN;
            endcase
        end
    end

    // Status flags decode the registered state, so they move on the same
    // edge that enters or leaves HALT/FAULT.
    always_comb begin
        imem_addr = pc;
        halted    = (state == S_HALT);
        fault     = (state == S_FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= 8'h00;
            if_pc       <= 8'h00;
            fetch_count <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            if_valid <= 1'b0;
        end else if (stall) begin
            pc <= pc;
        end else if (fetch_en) begin
            if_valid <= 1'b1;
            if_instr <= imem_data;
            if_pc    <= pc;
            pc       <= next_pc;
            if (fetch_count != {COUNT_W{1'b1}}) begin
                fetch_count <= fetch_count + 1'b1;
            end
        end else begin
            if_valid <= 1'b0;
        end
    end

endmodule
